// File: rtl/msk_rnd_gen.sv
// Fresh-randomness producer for masked gadgets: a seedable 128-bit Fibonacci LFSR
// with warm-up and NRND steps per accepted cycle. Optional macro MSK_RND_GATE_EN zeroes rnd while not valid.
module msk_rnd_gen #(
    parameter int NRND   = 1,
    parameter int WARMUP = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [127:0]    seed,
    input  logic            seed_valid,
    output logic            seed_ready,
    output logic [NRND-1:0] rnd,
    output logic            rnd_valid,
    input  logic            rnd_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_e;

    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP - 1);

    state_e          state_q, state_d;
    logic [127:0]    s_q, s_d, s_adv;
    logic [7:0]      cnt_q, cnt_d;
    logic [NRND-1:0] rnd_q, rnd_d;
    logic            seed_fire;

    function automatic logic [127:0] lfsr_step(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    endfunction

    // NRND single steps chained combinationally so one clock yields a whole word.
    always_comb begin
        s_adv = s_q;
        for (int i = 0; i < NRND; i++) begin
            s_adv = lfsr_step(s_adv);
        end
    end

    assign seed_ready = (state_q != ST_WARMUP);
    assign rnd_valid  = (state_q == ST_RUN);
    assign seed_fire  = seed_valid && seed_ready;
    assign rnd        = rnd_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_fire) begin
                    s_d     = (seed == '0) ? 128'h1 : seed;
                    cnt_d   = '0;
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                s_d   = s_adv;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WARMUP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A reseed takes priority over consumption on the same edge.
                if (seed_fire) begin
                    s_d     = (seed == '0) ? 128'h1 : seed;
                    cnt_d   = '0;
                    state_d = ST_WARMUP;
                end else if (rnd_ready) begin
                    s_d = s_adv;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output word is computed from the next state so rnd stays a plain flop output.
    always_comb begin
        rnd_d = '0;
`ifdef MSK_RND_GATE_EN
        if (state_d == ST_RUN) begin
            rnd_d = s_d[NRND-1:0];
        end
`else
        rnd_d = s_d[NRND-1:0];
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule
